// File: rtl/proc_slot_acc.sv
// proc_slot_acc - slot accumulator stage of the 4-slot symbol detector.
//
// Counts '1' samples of a serial hard-decision stream over four consecutive
// slots (A, B, C, D) of NDATA accepted samples each, then hands the four
// counts to proc_comp in parallel with a one-cycle valid strobe.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   din       in   hard-decision sample
//   dinValid  in   sample qualifier
//   sync      in   symbol-start marker (only meaningful with dinValid=1)
//   doutA..D  out  ones-count per slot, NDATA_LOG+1 bits, held until next symbol
//   doutValid out  one-cycle pulse when doutA..D carry a new symbol
//   locked    out  high while a symbol is being accumulated
module proc_slot_acc #(
  parameter int NDATA     = 128,
  parameter int NDATA_LOG = $clog2(NDATA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 dinValid,
  input  logic                 sync,
  output logic [NDATA_LOG:0]   doutA,
  output logic [NDATA_LOG:0]   doutB,
  output logic [NDATA_LOG:0]   doutC,
  output logic [NDATA_LOG:0]   doutD,
  output logic                 doutValid,
  output logic                 locked
);

  localparam int CW = NDATA_LOG + 1;
  localparam logic [NDATA_LOG-1:0] LAST_SAMPLE = NDATA_LOG'(NDATA - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_r, stateNxt_s;
  logic [NDATA_LOG-1:0]   sampleCnt_r, sampleCntNxt_s;
  logic [1:0]             slotIdx_r, slotIdxNxt_s;
  logic [CW-1:0]          acc_r [4];
  logic [CW-1:0]          accNxt_s [4];
  logic [CW-1:0]          dout_r [4];
  logic [CW-1:0]          doutNxt_s [4];
  logic                   doutValid_r, doutValidNxt_s;
  logic                   locked_r;
  logic [CW-1:0]          dinExt_s;

  assign dinExt_s = {{NDATA_LOG{1'b0}}, din};

  // Next-state logic: symbol start/resync, per-sample accumulation, completion.
  always_comb begin
    stateNxt_s     = state_r;
    sampleCntNxt_s = sampleCnt_r;
    slotIdxNxt_s   = slotIdx_r;
    accNxt_s       = acc_r;
    doutNxt_s      = dout_r;
    doutValidNxt_s = 1'b0;
    case (state_r)
      IDLE, RUN: begin
        if (dinValid && sync) begin
          // A sync sample always opens a fresh symbol as sample 0 of slot A,
          // abandoning any partial one (including on the last sample of D).
          stateNxt_s     = RUN;
          for (int i = 0; i < 4; i++) begin
            accNxt_s[i] = '0;
          end
          accNxt_s[0]    = dinExt_s;
          sampleCntNxt_s = NDATA_LOG'(1);
          slotIdxNxt_s   = 2'd0;
        end else if (dinValid && (state_r == RUN)) begin
          accNxt_s[slotIdx_r] = acc_r[slotIdx_r] + dinExt_s;
          if (sampleCnt_r == LAST_SAMPLE) begin
            sampleCntNxt_s = '0;
            if (slotIdx_r == 2'd3) begin
              // Last sample of slot D: publish, then chain into the next symbol.
              doutNxt_s[0]   = acc_r[0];
              doutNxt_s[1]   = acc_r[1];
              doutNxt_s[2]   = acc_r[2];
              doutNxt_s[3]   = acc_r[3] + dinExt_s;
              doutValidNxt_s = 1'b1;
              for (int i = 0; i < 4; i++) begin
                accNxt_s[i] = '0;
              end
              slotIdxNxt_s   = 2'd0;
            end else begin
              slotIdxNxt_s = slotIdx_r + 2'd1;
            end
          end else begin
            sampleCntNxt_s = sampleCnt_r + NDATA_LOG'(1);
          end
        end else begin
          stateNxt_s = state_r;
        end
      end
      default: begin
        stateNxt_s     = IDLE;
        sampleCntNxt_s = '0;
        slotIdxNxt_s   = 2'd0;
        for (int i = 0; i < 4; i++) begin
          accNxt_s[i] = '0;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sampleCnt_r <= '0;
      slotIdx_r   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        acc_r[i]  <= '0;
        dout_r[i] <= '0;
      end
      doutValid_r <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= stateNxt_s;
      sampleCnt_r <= sampleCntNxt_s;
      slotIdx_r   <= slotIdxNxt_s;
      acc_r       <= accNxt_s;
      dout_r      <= doutNxt_s;
      doutValid_r <= doutValidNxt_s;
      locked_r    <= (stateNxt_s == RUN);
    end
  end

  assign doutA     = dout_r[0];
  assign doutB     = dout_r[1];
  assign doutC     = dout_r[2];
  assign doutD     = dout_r[3];
  assign doutValid = doutValid_r;
  assign locked    = locked_r;

endmodule

// File: tb/tb_proc_slot_acc.sv
// Testbench for proc_slot_acc: two instances (NDATA=128 and NDATA=4) share one
// input stream; each is checked every cycle against a symbol-level model.
module tb_proc_slot_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dinValid = 1'b0;
  logic sync = 1'b0;

  logic [7:0] dA128, dB128, dC128, dD128;
  logic       dv128, lk128;
  logic [2:0] dA4, dB4, dC4, dD4;
  logic       dv4, lk4;

  int assertCnt = 0;
  int failCnt   = 0;

  // Model state: index 0 = NDATA 128, index 1 = NDATA 4.
  int  mPos [2];
  int  mOnes [2][4];
  bit  mRun [2];
  int  expOut [2][4];
  bit  expValid [2];
  int  pulses [2];

  always #5 clk = ~clk;

  proc_slot_acc #(.NDATA(128)) dut128 (
    .clk(clk), .rst(rst), .din(din), .dinValid(dinValid), .sync(sync),
    .doutA(dA128), .doutB(dB128), .doutC(dC128), .doutD(dD128),
    .doutValid(dv128), .locked(lk128)
  );

  proc_slot_acc #(.NDATA(4)) dut4 (
    .clk(clk), .rst(rst), .din(din), .dinValid(dinValid), .sync(sync),
    .doutA(dA4), .doutB(dB4), .doutC(dC4), .doutD(dD4),
    .doutValid(dv4), .locked(lk4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Symbol-level reference: position within symbol decides the slot.
  task automatic modelEdge(input logic d, input logic v, input logic s, input logic r);
    for (int k = 0; k < 2; k++) begin
      int nd;
      nd = (k == 0) ? 128 : 4;
      expValid[k] = 1'b0;
      if (r) begin
        mRun[k] = 1'b0;
        mPos[k] = 0;
        for (int j = 0; j < 4; j++) begin
          mOnes[k][j] = 0;
          expOut[k][j] = 0;
        end
      end else if (v) begin
        if (s) begin
          mRun[k] = 1'b1;
          mPos[k] = 0;
          for (int j = 0; j < 4; j++) mOnes[k][j] = 0;
        end
        if (mRun[k]) begin
          mOnes[k][mPos[k] / nd] += int'(d);
          mPos[k]++;
          if (mPos[k] == 4 * nd) begin
            for (int j = 0; j < 4; j++) begin
              expOut[k][j] = mOnes[k][j];
              mOnes[k][j] = 0;
            end
            expValid[k] = 1'b1;
            mPos[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic checkAll();
    chk("A128", 32'(dA128), expOut[0][0]);
    chk("B128", 32'(dB128), expOut[0][1]);
    chk("C128", 32'(dC128), expOut[0][2]);
    chk("D128", 32'(dD128), expOut[0][3]);
    chk("valid128", 32'(dv128), 32'(expValid[0]));
    chk("locked128", 32'(lk128), 32'(mRun[0]));
    chk("A4", 32'(dA4), expOut[1][0]);
    chk("B4", 32'(dB4), expOut[1][1]);
    chk("C4", 32'(dC4), expOut[1][2]);
    chk("D4", 32'(dD4), expOut[1][3]);
    chk("valid4", 32'(dv4), 32'(expValid[1]));
    chk("locked4", 32'(lk4), 32'(mRun[1]));
    if (dv128 === 1'b1) pulses[0]++;
    if (dv4 === 1'b1) pulses[1]++;
  endtask

  task automatic step(input logic d, input logic v, input logic s, input logic r);
    @(negedge clk);
    din = d; dinValid = v; sync = s; rst = r;
    @(posedge clk);
    modelEdge(d, v, s, r);
    #1;
    checkAll();
  endtask

  // Valid sample, optionally preceded by random idle gaps with noise on din/sync.
  task automatic sample(input logic d, input logic s, input int maxGap);
    int gap;
    gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
    for (int g = 0; g < gap; g++) begin
      step(1'($urandom), 1'b0, 1'($urandom), 1'b0);
    end
    step(d, 1'b1, s, 1'b0);
  endtask

  initial begin
    logic [15:0] pat;

    // 1: reset, then unsynchronised ones are ignored.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_doutA128", 32'(dA128), 32'd0);
    chk("reset_locked4", 32'(lk4), 32'd0);
    pulses[0] = 0; pulses[1] = 0;
    for (int i = 0; i < 600; i++) sample(1'b1, 1'b0, 0);
    chk("t1_pulses128", 32'(pulses[0]), 32'd0);
    chk("t1_pulses4", 32'(pulses[1]), 32'd0);
    chk("t1_locked128", 32'(lk128), 32'd0);

    // 2: NDATA=128, slot A all ones, rest zero.
    pulses[0] = 0;
    for (int i = 0; i < 512; i++) sample(logic'(i < 128), logic'(i == 0), 0);
    chk("t2_pulses128", 32'(pulses[0]), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_A128", 32'(dA128), 32'd128);
    chk("t2_B128", 32'(dB128), 32'd0);
    chk("t2_D128", 32'(dD128), 32'd0);

    // 3: NDATA=4, pattern 1011 0001 1111 0000 with random gaps.
    pat = 16'b1011_0001_1111_0000;
    pulses[1] = 0;
    for (int i = 0; i < 16; i++) sample(pat[15-i], logic'(i == 0), 3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_pulses4", 32'(pulses[1]), 32'd1);
    chk("t3_A4", 32'(dA4), 32'd3);
    chk("t3_B4", 32'(dB4), 32'd1);
    chk("t3_C4", 32'(dC4), 32'd4);
    chk("t3_D4", 32'(dD4), 32'd0);

    // 4: two chained symbols, second without sync.
    pulses[1] = 0;
    for (int i = 0; i < 16; i++) sample(logic'(i < 4), logic'(i == 0), 0);
    for (int i = 0; i < 16; i++) sample(logic'(i >= 14), 1'b0, 0);
    chk("t4_pulses4", 32'(pulses[1]), 32'd2);
    chk("t4_D4", 32'(dD4), 32'd2);
    chk("t4_A4", 32'(dA4), 32'd0);

    // 5: partial symbol abandoned by a second sync.
    pulses[1] = 0;
    for (int i = 0; i < 6; i++) sample(1'($urandom), logic'(i == 0), 2);
    for (int i = 0; i < 16; i++) sample(logic'(i >= 4 && i < 8), logic'(i == 0), 2);
    chk("t5_pulses4", 32'(pulses[1]), 32'd1);
    chk("t5_B4", 32'(dB4), 32'd4);
    chk("t5_A4", 32'(dA4), 32'd0);

    // 7: sync on the final sample of slot D wins over completion.
    pulses[1] = 0;
    for (int i = 0; i < 16; i++) sample(1'($urandom), logic'(i == 0 || i == 15), 1);
    chk("t7_nopulse4", 32'(pulses[1]), 32'd0);
    for (int i = 0; i < 15; i++) sample(1'($urandom), 1'b0, 1);
    chk("t7_pulse4", 32'(pulses[1]), 32'd1);

    // 6: reset mid-slot C, then unsynced samples, then a fresh sync.
    for (int i = 0; i < 9; i++) sample(1'($urandom), logic'(i == 0), 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    pulses[1] = 0;
    for (int i = 0; i < 16; i++) sample(1'($urandom), 1'b0, 1);
    chk("t6_pulses4", 32'(pulses[1]), 32'd0);
    chk("t6_locked4", 32'(lk4), 32'd0);
    chk("t6_C4", 32'(dC4), 32'd0);
    for (int i = 0; i < 16; i++) sample(1'($urandom), logic'(i == 0), 2);
    chk("t6_restart4", 32'(pulses[1]), 32'd1);
    chk("t6_relock4", 32'(lk4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
